// File: rtl/ex_mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the EX stage.
// Define MULT_DIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle product.
module ex_mult_div_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CNT_WIDTH = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic             i_flush,
   input  logic             i_mf_req,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_stall_req
);

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_t;

   state_t                 r_state;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [2*WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]       r_mcand;
   logic                   r_neg_q;
   logic                   r_neg_r;
   logic                   r_is_div;
   logic                   r_div0;
   logic [WIDTH-1:0]       r_hi;
   logic [WIDTH-1:0]       r_lo;
   logic                   r_done;

   logic                   w_signed;
   logic                   w_a_neg;
   logic                   w_b_neg;
   logic [WIDTH-1:0]       w_mag_a;
   logic [WIDTH-1:0]       w_mag_b;
   logic [WIDTH:0]         w_sum;
   logic [WIDTH:0]         w_rem_sh;
   logic [WIDTH:0]         w_diff;
   logic                   w_q_bit;
   logic [WIDTH-1:0]       w_rem_nx;
   logic [2*WIDTH-1:0]     w_prod;
   logic [WIDTH-1:0]       w_quo;
   logic [WIDTH-1:0]       w_rem;
   logic                   w_last;

   always_comb begin
      w_signed = (i_op == OpMult) || (i_op == OpDiv);
      w_a_neg  = w_signed & i_operand_a[WIDTH-1];
      w_b_neg  = w_signed & i_operand_b[WIDTH-1];
      w_mag_a  = w_a_neg ? -i_operand_a : i_operand_a;
      w_mag_b  = w_b_neg ? -i_operand_b : i_operand_b;
      // Multiply: {hi,lo} holds partial product above the unconsumed multiplier bits.
      w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
      // Divide: {rem,dividend} shifts left; quotient bits fill in from the bottom.
      w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_diff   = w_rem_sh - {1'b0, r_mcand};
      w_q_bit  = ~w_diff[WIDTH];
      w_rem_nx = w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
      w_prod   = r_neg_q ? -r_acc : r_acc;
      w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_last   = (r_cnt == CNT_WIDTH'(WIDTH - 1));
   end

`ifdef MULT_DIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] w_fast_prod;
   assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_div <= 1'b0;
         r_div0   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start && !i_flush) begin
                  case (i_op)
                     OpMult, OpMultu: begin
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_is_div <= 1'b0;
                        r_div0   <= 1'b0;
                        r_cnt    <= '0;
`ifdef MULT_DIV_FAST_MUL_EN
                        r_acc    <= w_fast_prod;
                        r_state  <= StFix;
`else
                        r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                        r_mcand  <= w_mag_a;
                        r_state  <= StMul;
`endif
                     end
                     OpDiv, OpDivu: begin
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_is_div <= 1'b1;
                        r_cnt    <= '0;
                        r_mcand  <= w_mag_b;
                        if (i_operand_b == '0) begin
                           // Raw dividend parked in the low half so FIX can copy it to HI.
                           r_div0  <= 1'b1;
                           r_acc   <= {{WIDTH{1'b0}}, i_operand_a};
                           r_state <= StFix;
                        end else begin
                           r_div0  <= 1'b0;
                           r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                           r_state <= StDiv;
                        end
                     end
                     OpMthi:  r_hi <= i_operand_a;
                     OpMtlo:  r_lo <= i_operand_a;
                     default: ;
                  endcase
               end
            end
            StMul: begin
               if (i_flush) begin
                  r_state <= StIdle;
               end else begin
                  r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                  if (w_last) r_state <= StFix;
                  else        r_cnt   <= r_cnt + CNT_WIDTH'(1);
               end
            end
            StDiv: begin
               if (i_flush) begin
                  r_state <= StIdle;
               end else begin
                  r_acc <= {w_rem_nx, r_acc[WIDTH-2:0], w_q_bit};
                  if (w_last) r_state <= StFix;
                  else        r_cnt   <= r_cnt + CNT_WIDTH'(1);
               end
            end
            StFix: begin
               r_state <= StIdle;
               if (!i_flush) begin
                  r_done <= 1'b1;
                  if (!r_is_div) begin
                     {r_hi, r_lo} <= w_prod;
                  end else if (r_div0) begin
                     r_lo <= '1;
                     r_hi <= r_acc[WIDTH-1:0];
                  end else begin
                     r_lo <= w_quo;
                     r_hi <= w_rem;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_hi        = r_hi;
   assign o_lo        = r_lo;
   assign o_busy      = (r_state != StIdle);
   assign o_done      = r_done;
   assign o_stall_req = o_busy & (i_start | i_mf_req);

endmodule

// File: tb/tb_ex_mult_div_unit.sv
// Bench for ex_mult_div_unit: directed vectors plus random ops against an arithmetic model.
// Honours MULT_DIV_FAST_MUL_EN for the expected multiply latency.
module tb_ex_mult_div_unit;
   localparam int W = 32;
`ifdef MULT_DIV_FAST_MUL_EN
   localparam int MulLat     = 1;
   localparam int FlushEdge  = 1;
`else
   localparam int MulLat     = W + 1;
   localparam int FlushEdge  = 10;
`endif
   localparam int DivLat = W + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          flush;
   logic          mf_req;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          busy;
   logic          done;
   logic          stall_req;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] s_hi = '0;
   logic [W-1:0] s_lo = '0;

   always #5 clk = ~clk;

   ex_mult_div_unit #(.WIDTH(W), .CNT_WIDTH(6)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_op        (op),
      .i_operand_a (a),
      .i_operand_b (b),
      .i_flush     (flush),
      .i_mf_req    (mf_req),
      .o_hi        (hi),
      .o_lo        (lo),
      .o_busy      (busy),
      .o_done      (done),
      .o_stall_req (stall_req)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // MIPS semantics: truncating division, remainder takes dividend sign, /0 gives lo=~0 hi=a.
   task automatic model(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        output logic [W-1:0] eh, output logic [W-1:0] el);
      longint sa, sb, sq, sr;
      logic [63:0] up;
      sa = $signed(va);
      sb = $signed(vb);
      eh = '0;
      el = '0;
      case (o)
         3'd0: begin sq = sa * sb; up = sq; {eh, el} = up; end
         3'd1: begin up = {32'b0, va} * {32'b0, vb}; {eh, el} = up; end
         3'd2, 3'd3: begin
            if (vb == '0) begin
               el = '1;
               eh = va;
            end else if (o == 3'd2) begin
               sq = sa / sb;
               sr = sa % sb;
               up = sq; el = up[31:0];
               up = sr; eh = up[31:0];
            end else begin
               el = va / vb;
               eh = va % vb;
            end
         end
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input string tag);
      logic [W-1:0] eh, el;
      int lat, cyc;
      model(o, va, vb, eh, el);
      if (o <= 3'd1)       lat = MulLat;
      else if (vb == '0)   lat = 1;
      else                 lat = DivLat;
      @(negedge clk);
      start = 1'b1; op = o; a = va; b = vb;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      mf_req = 1'b1; #1;
      check({tag, "_stall"}, 64'(stall_req), 64'd1);
      mf_req = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_lat"}, 64'(cyc), 64'(lat));
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      check({tag, "_idle"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      check({tag, "_donepulse"}, 64'(done), 64'd0);
      s_hi = eh;
      s_lo = el;
   endtask

   task automatic mt(input logic to_hi, input logic [W-1:0] v, input string tag);
      @(negedge clk);
      start = 1'b1; op = to_hi ? 3'd4 : 3'd5; a = v; b = '0;
      @(posedge clk); #1;
      start = 1'b0;
      if (to_hi) s_hi = v; else s_lo = v;
      check({tag, "_hi"}, 64'(hi), 64'(s_hi));
      check({tag, "_lo"}, 64'(lo), 64'(s_lo));
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      int dones, cyc;
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0; mf_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mf_req = 1'b1; #1;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_stall", 64'(stall_req), 64'd0);
      mf_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
      check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
      check("div_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      run_op(3'd3, 32'd100, 32'd7, "divu_small");
      check("divu_small_hi_const", 64'(hi), 64'd2);
      run_op(3'd3, 32'h0000_1234, 32'd0, "divu_zero");
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
      check("div_min_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
      run_op(3'd2, 32'h8000_0001, 32'h0000_0000, "div_zero_s");
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_min");

      // Flush mid-multiply: HI/LO keep the MTHI value, no done
      mt(1'b1, 32'hA5A5_A5A5, "mthi");
      mt(1'b0, 32'h0BAD_F00D, "mtlo");
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (FlushEdge - 1) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      dones = (done === 1'b1) ? 1 : 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      check("flush_nodone", 64'(dones), 64'd0);
      check("flush_hi", 64'(hi), 64'hA5A5_A5A5);
      check("flush_lo", 64'(lo), 64'(s_lo));

      // start with flush while idle is dropped
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'h1111_2222;
      @(posedge clk); #1;
      check("sf_mtlo", 64'(lo), 64'(s_lo));
      op = 3'd3; a = 32'd50; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("sf_div_busy", 64'(busy), 64'd0);

      // start while busy is ignored
      @(negedge clk);
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; #1;
      check("busy_start_stall", 64'(stall_req), 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_start_hi", 64'(hi), 64'hA5A5_A5A5);
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("busy_start_lat", 64'(cyc + 4), 64'(DivLat));
      check("busy_start_q", 64'(lo), 64'hE);
      check("busy_start_r", 64'(hi), 64'h2);
      s_hi = 32'h2; s_lo = 32'hE;

      // Async reset mid-divide clears immediately
      @(negedge clk);
      start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0; #1;
      check("arst_hi", 64'(hi), 64'd0);
      check("arst_lo", 64'(lo), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      s_hi = '0; s_lo = '0;

      for (int i = 0; i < 30; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 7) == 0) rb = '0;
         else if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 15));
         run_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
